multi_digit_counter: RTL
========================

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter DIGITS, default 4, is the number of 4-bit digits (legal 1..8).
REQ-002 Parameter RADIX, default 16, is the per-digit modulus (legal 16 = binary or 10 = BCD).
REQ-003 Parameter SELW, default max(1,clog2(DIGITS)), is the Digit select width.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 nCLR  in  1  reset, asynchronous, active-low.
REQ-006 nSCLR  in  1  synchronous clear of count, active-low.
REQ-007 nLOAD  in  1  active-low load of the count digit selected by Digit.
REQ-008 nRLD  in  1  active-low write of the reload-register digit selected by Digit.
REQ-009 Digit  in  SELW  digit select for nLOAD/nRLD; 0 = least significant.
REQ-010 Din  in  4  load/reload data.
REQ-011 ENP, ENT  in  1 each  count enables; count only when both are 1.
REQ-012 UP  in  1  direction: 1 = up, 0 = down.
REQ-013 AUTO  in  1  1 = on terminal count, reload from reload register instead of wrapping.
REQ-014 CLR_OVF  in  1  synchronous clear of OVF.
REQ-015 Dout  out  4*DIGITS  count; digit i on bits [4i+3:4i].
REQ-016 RCO  out  1  ripple carry/borrow out, combinational.
REQ-017 OVF  out  1  sticky terminal-count-passed flag.

Function
REQ-018 Per-edge priority: nSCLR=0 (all digits 0) > nLOAD=0 (selected digit <= Din, others hold) > count > hold.
REQ-019 Digit >= DIGITS with nLOAD or nRLD low has no effect.
REQ-020 Din >= RADIX written by load or reload stores 0.
REQ-021 Terminal digit value: RADIX-1 when UP=1, 0 when UP=0.
REQ-022 Count up: digit i increments modulo RADIX when ENP=ENT=1 and all digits below i are terminal; down: decrements modulo RADIX likewise.
REQ-023 RCO = ENT AND every digit terminal for the current UP; independent of ENP; no register delay.
REQ-024 Counting when RCO=1 and ENP=1 is a rollover: AUTO=0 gives all-0 (up) or all-(RADIX-1) (down); AUTO=1 gives count <= reload register in that same edge.
REQ-025 OVF sets on every rollover edge, holds until CLR_OVF=1 or reset; rollover and CLR_OVF on the same edge leaves OVF=1.
REQ-026 nSCLR and nLOAD do not change OVF or the reload register.
REQ-027 nRLD=0 writes the selected reload digit at the same edge as any count activity; a reload rollover in that edge uses the old reload value.
REQ-028 UP change takes effect at the next edge; no extra latency.

Reset
REQ-029 nCLR=0 asynchronously forces Dout=0, OVF=0, reload register=0; RCO then follows REQ-023.
REQ-030 Deassertion of nCLR is synchronised by the integrator; first count edge is the first rising CLK after release.

Structure
REQ-031 Shared package holds RADIX_BIN=16, RADIX_BCD=10, DIGIT_W=4.
REQ-032 Sub-module counter_digit (one 4-bit slice: clear/load/inc/dec modulo RADIX, terminal flag) is instantiated DIGITS times via generate; carry chain and OVF live in the top.

Verification
REQ-033 DIGITS=4 RADIX=16 UP=1: load 0xFFFE via 4 digit loads, count 1 -> Dout=0xFFFF RCO=1; count 1 -> 0x0000, OVF=1.
REQ-034 RADIX=10: load 0999, count 1 -> 1000, RCO=0 before and after, OVF=0.
REQ-035 UP=0 AUTO=1, reload 0x0500, count 0x0001 -> 0x0000 (RCO=1) -> 0x0500, OVF=1.
REQ-036 nSCLR=0 and nLOAD=0 same edge from 0x1234 -> 0x0000; load Din=0xC in RADIX=10 -> digit 0.
REQ-037 nCLR pulse mid-count off-edge -> Dout=0 and OVF=0 immediately; ENT=0 ENP=1 -> hold, RCO=0.

Source files
------------

// File: rtl/multi_digit_counter_pkg.sv
// Shared constants, digit-slice opcodes and helpers for the multi-digit up/down counter.
package multi_digit_counter_pkg;

  localparam int RADIX_BIN = 16;
  localparam int RADIX_BCD = 10;
  localparam int DIGIT_W   = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } digit_op_e;

  function automatic int sel_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  // Out-of-range digit codes (e.g. 0xA..0xF in BCD) are stored as zero.
  function automatic logic [DIGIT_W-1:0] legal_digit(input logic [DIGIT_W-1:0] v,
                                                     input int radix);
    return (int'(v) < radix) ? v : '0;
  endfunction

endpackage

// File: rtl/multi_digit_counter_if.sv
// Control and status bundle of the multi-digit counter; clock and reset stay plain ports.
interface multi_digit_counter_if
  import multi_digit_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SELW   = sel_w(DIGITS)
);

  logic                      nSCLR;
  logic                      nLOAD;
  logic                      nRLD;
  logic [SELW-1:0]           Digit;
  logic [DIGIT_W-1:0]        Din;
  logic                      ENP;
  logic                      ENT;
  logic                      UP;
  logic                      AUTO;
  logic                      CLR_OVF;
  logic [DIGIT_W*DIGITS-1:0] Dout;
  logic                      RCO;
  logic                      OVF;

  modport master (
    output nSCLR, nLOAD, nRLD, Digit, Din, ENP, ENT, UP, AUTO, CLR_OVF,
    input  Dout, RCO, OVF
  );

  modport slave (
    input  nSCLR, nLOAD, nRLD, Digit, Din, ENP, ENT, UP, AUTO, CLR_OVF,
    output Dout, RCO, OVF
  );

endinterface

// File: rtl/multi_digit_counter_digit.sv
// One 4-bit counter slice: clear, load, increment or decrement modulo RADIX, plus
// a terminal flag that reflects the current count direction.
module counter_digit
  import multi_digit_counter_pkg::*;
#(
  parameter int RADIX = RADIX_BIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  digit_op_e          i_op,
  input  logic [DIGIT_W-1:0] i_load_val,
  input  logic               i_up,
  output logic [DIGIT_W-1:0] o_val,
  output logic               o_term
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] r_val;
  logic [DIGIT_W-1:0] w_next;

  // NOTE: every variable written here gets a value before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_val;
    case (i_op)
      OP_CLEAR: w_next = '0;
      OP_LOAD:  w_next = legal_digit(i_load_val, RADIX);
      OP_INC:   w_next = (r_val == MAX_VAL) ? '0 : r_val + 1'b1;
      OP_DEC:   w_next = (r_val == '0) ? MAX_VAL : r_val - 1'b1;
      default:  w_next = r_val;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
    end else begin
      r_val <= w_next;
    end
  end

  assign o_val  = r_val;
  assign o_term = i_up ? (r_val == MAX_VAL) : (r_val == '0);

endmodule

// File: rtl/multi_digit_counter.sv
// Cascadable multi-digit binary/BCD up/down counter with per-digit load, reload
// register for auto-reload on terminal count, combinational RCO and sticky OVF.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = RADIX_BIN,
  parameter int SELW   = sel_w(DIGITS)
) (
  input  logic                 CLK,
  input  logic                 nCLR,
  multi_digit_counter_if.slave bus
);

  logic [SELW-1:0]           w_sel;
  logic                      w_sel_valid;
  logic                      w_load_act;
  logic                      w_count_act;
  logic                      w_rollover;
  logic [DIGITS-1:0]         w_term;
  logic [DIGITS:0]           w_below_term;
  logic [DIGIT_W*DIGITS-1:0] w_dout;
  logic                      r_ovf;

  assign w_sel       = bus.Digit;
  assign w_sel_valid = int'(w_sel) < DIGITS;

  // A load aimed at a non-existent digit is ignored entirely, counting proceeds.
  assign w_load_act  = !bus.nLOAD && w_sel_valid;
  assign w_count_act = bus.nSCLR && !w_load_act && bus.ENP && bus.ENT;

  // w_below_term[i] is high when every digit below i sits at its terminal value.
  always_comb begin
    w_below_term[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_below_term[k+1] = w_below_term[k] & w_term[k];
    end
  end

  assign w_rollover = w_count_act && w_below_term[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    digit_op_e          w_op;
    logic [DIGIT_W-1:0] w_load_val;
    logic [DIGIT_W-1:0] w_val;
    logic [DIGIT_W-1:0] r_reload;
    logic               w_hit;

    assign w_hit = (int'(w_sel) == i);

    // NOTE: the reload bank is a handful of flops rather than a RAM, so it takes
    // the asynchronous clear along with the count.
    always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
        r_reload <= '0;
      end else if (!bus.nRLD && w_hit) begin
        r_reload <= legal_digit(bus.Din, RADIX);
      end
    end

    always_comb begin
      w_op       = OP_HOLD;
      w_load_val = r_reload;
      if (!bus.nSCLR) begin
        w_op = OP_CLEAR;
      end else if (w_load_act) begin
        if (w_hit) begin
          w_op       = OP_LOAD;
          w_load_val = bus.Din;
        end
      end else if (w_count_act) begin
        if (w_rollover && bus.AUTO) begin
          w_op = OP_LOAD;
        end else if (w_below_term[i]) begin
          w_op = bus.UP ? OP_INC : OP_DEC;
        end
      end
    end

    counter_digit #(
      .RADIX (RADIX)
    ) u_digit (
      .clk        (CLK),
      .rst_n      (nCLR),
      .i_op       (w_op),
      .i_load_val (w_load_val),
      .i_up       (bus.UP),
      .o_val      (w_val),
      .o_term     (w_term[i])
    );

    assign w_dout[DIGIT_W*i +: DIGIT_W] = w_val;
  end

  // A rollover wins over a simultaneous CLR_OVF so no terminal event is lost.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      r_ovf <= 1'b0;
    end else if (w_rollover) begin
      r_ovf <= 1'b1;
    end else if (bus.CLR_OVF) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.Dout = w_dout;
  assign bus.RCO  = bus.ENT && w_below_term[DIGITS];
  assign bus.OVF  = r_ovf;

endmodule
